inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port im_req  output  1  instruction-memory read request.
REQ-005 SHALL have port im_addr  output  32  byte address of the request.
REQ-006 SHALL have port im_ack  input  1  one-cycle acknowledge; im_rdata is valid in the same cycle.
REQ-007 SHALL have port im_rdata  input  32  instruction word.
REQ-008 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc  input  32  target address, sampled when redirect=1.
REQ-010 SHALL have port id_ready  input  1  the decode stage accepts the head instruction.
REQ-011 SHALL have port id_valid  output  1  the head instruction is valid.
REQ-012 SHALL have port id_inst  output  32  head instruction word.
REQ-013 SHALL have port id_pc  output  32  head instruction address.
REQ-014 SHALL have port OP  output  7  id_inst[6:0], the opcode driven to the control unit.

Function
REQ-015 SHALL hold a 2-entry FIFO of {pc, inst}; id_valid = (count != 0); id_inst, id_pc and OP are taken from the head entry.
REQ-016 SHALL pop the head on any cycle where id_valid && id_ready.
REQ-017 SHALL use a three-state FSM: IDLE, FETCH, DROP; at most one request outstanding.
REQ-018 SHALL assert im_req = 1 in FETCH and in DROP, and im_req = 0 in IDLE.
REQ-019 SHALL drive im_addr = pc in FETCH; in DROP, im_addr SHALL hold the address of the outstanding request.
REQ-020 SHALL keep im_addr stable while im_req = 1 until im_ack.
REQ-021 IDLE SHALL move to FETCH on the next edge when count < 2 (count taken after this cycle's pop).
REQ-022 In FETCH, on im_ack without redirect, the block SHALL push {pc, im_rdata} and set pc <= pc + 4 (mod 2^32).
- After the push it SHALL stay in FETCH if the resulting count < 2, else go to IDLE.
REQ-023 A push SHALL never occur when the FIFO is full; FETCH is only entered with space, and pops never add entries.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 id_valid SHALL rise exactly one cycle after the im_ack that filled an empty FIFO.
REQ-026 On redirect, the block SHALL clear the FIFO (count <= 0), set pc <= redirect_pc, and suppress that cycle's pop and push.
- Redirect has priority over all other events.
REQ-027 Redirect in FETCH without im_ack SHALL go to DROP; the outstanding request SHALL be held to completion.
REQ-028 Redirect in FETCH with im_ack in the same cycle SHALL discard im_rdata and go to FETCH at redirect_pc.
REQ-029 In DROP, im_ack SHALL discard im_rdata and go to FETCH at the current pc.
- A redirect in DROP without im_ack SHALL update pc and stay in DROP.
- A redirect in DROP with im_ack SHALL update pc and go to FETCH.
REQ-030 Redirect in IDLE SHALL go to FETCH at redirect_pc on the next edge.

Reset
REQ-031 While rst_n = 0, the block SHALL hold: state = IDLE, pc = RESET_PC, count = 0, im_req = 0, id_valid = 0, im_addr = RESET_PC, id_inst = 0, id_pc = 0, OP = 0.
REQ-032 After rst_n rises, the FSM SHALL enter FETCH on the first edge, so im_req = 1 in the second cycle.
REQ-033 Reset asserted mid-request SHALL abandon the request.
- An im_ack arriving after reset deasserts while the FSM is in IDLE SHALL be ignored.

Configuration
REQ-034 When macro IF_PERF_EN is defined, the block SHALL add output perf_inst_cnt (32 bits).
- It increments by 1 per pop, wraps at 2^32, and resets to 0.
- Redirect does not clear it; flushed entries are not counted.
REQ-035 When IF_PERF_EN is undefined, the perf_inst_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Stream test: reset with RESET_PC = 0, memory acks every cycle, id_ready = 1.
- Required: im_addr sequence 0, 4, 8, ...
- Required: id_pc follows one cycle after each ack; OP = im_rdata[6:0].
REQ-037 Backpressure test: id_ready = 0.
- Required: exactly 2 acks accepted, then im_req = 0 with count = 2.
- Required: raising id_ready for 1 cycle causes im_req = 1 on the next cycle at address 8.
REQ-038 Redirect while waiting: im_addr = 8 with im_ack held 0, then redirect to 0x100.
- Required: state DROP, im_addr stays 8 until ack, that data is discarded.
- Required: next request at 0x100; no id_valid for the address-8 word.
REQ-039 Same-cycle redirect and ack: im_ack at addr 4 together with redirect to 0x40.
- Required: word dropped, FIFO empty, next im_addr = 0x40.
REQ-040 Wrap and reset test:
- Wrap: redirect to 0xFFFF_FFFC with two acks gives im_addr 0xFFFF_FFFC then 0x0000_0000.
- Reset: rst_n pulled low mid-request forces im_req = 0 and id_valid = 0 immediately (asynchronously).
REQ-041 With IF_PERF_EN defined: 5 pops, 1 redirect flushing 2 entries, then 3 pops.
- Required: perf_inst_cnt = 8.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch with one outstanding memory request and a 2-entry {pc, inst} queue to decode.
// Defining IF_PERF_EN adds perf_inst_cnt, the number of instructions handed to decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [6:0]  OP
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_inst_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetchState_t;

  fetchState_t stateQ, stateD;
  logic [31:0] pcQ;
  logic [31:0] dropAddrQ;
  logic [1:0]  count;
  logic [1:0]  countAfterPop;
  logic        rdPtr, wrPtr;
  logic [31:0] memPc   [2];
  logic [31:0] memInst [2];
  logic        push, pop;

  // Redirect squashes both queue operations in its cycle.
  assign pop           = id_valid & id_ready & ~redirect;
  assign push          = (stateQ == FETCH) & im_ack & ~redirect;
  assign countAfterPop = count - {1'b0, pop};

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (redirect || countAfterPop != 2'd2) stateD = FETCH;
      end
      FETCH: begin
        if (redirect)                             stateD = im_ack ? FETCH : DROP;
        else if (im_ack && countAfterPop != 2'd0) stateD = IDLE;
      end
      DROP: begin
        if (im_ack) stateD = FETCH;
      end
      default: stateD = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      pcQ       <= RESET_PC;
      dropAddrQ <= RESET_PC;
    end else begin
      stateQ <= stateD;
      if (redirect)  pcQ <= redirect_pc;
      else if (push) pcQ <= pcQ + 32'd4;
      // The abandoned request must keep its address on the bus until memory acks it.
      if (stateQ == FETCH && redirect && !im_ack) dropAddrQ <= pcQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
    end else if (redirect) begin
      count <= 2'd0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      count <= countAfterPop + {1'b0, push};
    end
  end

  // NOTE: queue storage is not reset; the outputs are gated by id_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      memPc[wrPtr]   <= pcQ;
      memInst[wrPtr] <= im_rdata;
    end
  end

  assign im_req   = (stateQ != IDLE);
  assign im_addr  = (stateQ == DROP) ? dropAddrQ : pcQ;
  assign id_valid = (count != 2'd0);
  assign id_inst  = id_valid ? memInst[rdPtr] : 32'd0;
  assign id_pc    = id_valid ? memPc[rdPtr]   : 32'd0;
  assign OP       = id_inst[6:0];

`ifdef IF_PERF_EN
  logic [31:0] perfCntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   perfCntQ <= 32'd0;
    else if (pop) perfCntQ <= perfCntQ + 32'd1;
  end

  assign perf_inst_cnt = perfCntQ;
`endif

endmodule
